// File: rtl/engine_pkg.sv
// rtl/engine_pkg.sv - shared widths, FSM encoding and slot-to-bit mapping for the instruction engine
package engine_pkg;

    localparam int INSTR_WIDTH     = 8;
    localparam int LINE_WIDTH      = 256;
    localparam int INSTRS_PER_LINE = 32;

    typedef enum logic {
        FILL  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Slot 0 sits in the most significant byte; the read side uses the same mapping.
    function automatic int slot_lsb(input int k);
        return LINE_WIDTH - INSTR_WIDTH * (k + 1);
    endfunction

endpackage

// File: rtl/instruction_packer.sv
// rtl/instruction_packer.sv - packs 32 instruction bytes into one 256-bit RAM line with flush and ack handshake
module instruction_packer
    import engine_pkg::*;
#(
    parameter int                     ADDR_WIDTH = 8,
    parameter logic [INSTR_WIDTH-1:0] PAD_INSTR  = 8'h00
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic [INSTR_WIDTH-1:0] inst_in,
    input  logic                   inst_valid,
    output logic                   inst_ready,
    input  logic                   flush,
    output logic [LINE_WIDTH-1:0]  dataBus,
    output logic [ADDR_WIDTH-1:0]  ram_address,
    output logic                   ram_write,
    input  logic                   ram_ack,
    output logic [4:0]             slot_count,
    output logic [ADDR_WIDTH-1:0]  lines_written
);

    localparam logic [4:0] LAST_SLOT = 5'(INSTRS_PER_LINE - 1);

    state_t                 state;
    state_t                 state_next;
    logic [INSTR_WIDTH-1:0] slots [INSTRS_PER_LINE];
    logic                   accept;

    assign inst_ready = (state == FILL) && !Reset;
    assign accept     = inst_valid && inst_ready;
    assign ram_write  = (state == WRITE);

    for (genvar k = 0; k < INSTRS_PER_LINE; k++) begin : g_slot
        assign dataBus[slot_lsb(k) +: INSTR_WIDTH] = slots[k];
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                // A byte arriving with flush is stored first, so the line is never empty.
                if (accept && (slot_count == LAST_SLOT || flush)) begin
                    state_next = WRITE;
                end else if (flush && slot_count != 5'd0) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (ram_ack) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state         <= FILL;
            slot_count    <= '0;
            ram_address   <= '0;
            lines_written <= '0;
            for (int k = 0; k < INSTRS_PER_LINE; k++) begin
                slots[k] <= PAD_INSTR;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                slots[slot_count] <= inst_in;
                slot_count        <= slot_count + 5'd1;
            end
            if (state == WRITE && ram_ack) begin
                ram_address   <= ram_address + ADDR_WIDTH'(1);
                lines_written <= lines_written + ADDR_WIDTH'(1);
                slot_count    <= '0;
                for (int k = 0; k < INSTRS_PER_LINE; k++) begin
                    slots[k] <= PAD_INSTR;
                end
            end
        end
    end

endmodule

// File: doc/instruction_packer.md
INSTRUCTION_PACKER -- requirements
Module: instruction_packer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, which sets the RAM line address width.
REQ-002 The block SHALL have parameter PAD_INSTR, default 8'h00, which is the instruction byte used to fill unused slots on flush.
REQ-003 The block SHALL use one clock, clk; reset SHALL be Reset, asynchronous and active-high.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous active-high reset.
- inst_in  in  8  instruction byte from the host/assembler stream.
- inst_valid  in  1  inst_in is valid.
- inst_ready  out  1  packer can accept a byte this cycle.
- flush  in  1  close a partial line: pad it and write it out.
- dataBus  out  256  packed instruction line.
- ram_address  out  ADDR_WIDTH  RAM line address of the current write.
- ram_write  out  1  write request, held until acknowledged.
- ram_ack  in  1  RAM accepted the write.
- slot_count  out  5  number of bytes held in the current line.
- lines_written  out  ADDR_WIDTH  count of completed line writes.

Function
REQ-005 The block SHALL pack 32 8-bit instructions into one 256-bit line.
- Slot k (k = 0..31) SHALL occupy dataBus[255-8k : 248-8k].
- Slot 0 is the first byte received, in bits [255:248].
REQ-006 States SHALL be FILL and WRITE.
- inst_ready SHALL equal (state==FILL) and not Reset.
REQ-007 In FILL, a byte SHALL be accepted on a rising clk edge when inst_valid and inst_ready are both high.
- The byte is stored in slot slot_count.
- slot_count then increments.
REQ-008 Accepting a byte into slot 31 SHALL move the FSM to WRITE.
- ram_write SHALL assert on the next cycle.
- Latency from the last byte accepted to ram_write high is 1 cycle.
REQ-009 flush in FILL with slot_count>0 SHALL move the FSM to WRITE.
- Slots slot_count..31 SHALL read PAD_INSTR.
REQ-010 flush in FILL with slot_count==0 and no byte accepted that cycle SHALL be ignored; no write of an empty line occurs.
REQ-011 inst_valid accepted and flush in the same cycle: the byte SHALL be stored first, then the flush applies, so the line includes that byte.
REQ-012 In WRITE, ram_write SHALL stay high, and dataBus and ram_address SHALL stay stable, until ram_ack is sampled high.
- inst_in and flush SHALL be ignored while in WRITE.
REQ-013 On ram_ack in WRITE, in one edge:
- ram_write deasserts.
- ram_address increments modulo 2^ADDR_WIDTH, wrapping from all-ones to 0.
- lines_written increments, also wrapping.
- slot_count clears to 0.
- All slots reset to PAD_INSTR.
- The FSM returns to FILL.
REQ-014 ram_ack sampled while in FILL SHALL be ignored.
REQ-015 The minimum line turnaround SHALL be: last byte, then 1 cycle, then ram_write, then ack, then inst_ready high on the cycle after the ack edge.

Reset
REQ-016 Assertion of Reset SHALL immediately, without waiting for clk, set:
- FSM to FILL.
- slot_count=0, ram_address=0, lines_written=0.
- ram_write=0, inst_ready=0.
- dataBus = {32{PAD_INSTR}}.
REQ-017 Reset asserted mid-line or mid-WRITE SHALL discard the partial or pending line; no write SHALL be issued for it after Reset deasserts.
REQ-018 After Reset deasserts, inst_ready SHALL be 1 and the first byte accepted SHALL go to slot 0 at ram_address 0.

Structure
REQ-019 A shared package (engine_pkg) SHALL hold:
- INSTR_WIDTH=8, LINE_WIDTH=256, INSTRS_PER_LINE=32.
- The FSM state encoding.
- The slot-to-bit-range mapping, shared with the instruction memory read side.
REQ-020 The block SHALL be a single module with no sub-module; slot storage SHALL be a 32x8 register array concatenated onto dataBus.

Verification
REQ-021 Full line: feed bytes 8'h00..8'h1F back-to-back, ack 3 cycles after ram_write rises.
- Expect dataBus=256'h000102...1E1F, ram_address=0, ram_write high 3 cycles.
- Then lines_written=1 and inst_ready=1.
REQ-022 Partial flush: feed 8'hA1, 8'hB2, 8'hC3, then flush.
- Expect dataBus[255:232]=24'hA1B2C3 and the remaining bits all PAD_INSTR.
- slot_count=3 during WRITE.
REQ-023 Simultaneous events:
- inst_valid with 8'h55 plus flush at slot_count=0 -> one-byte line 8'h55 followed by padding.
- flush alone at slot_count=0 -> no ram_write.
REQ-024 Backpressure: hold ram_ack low 10 cycles while inst_valid stays high.
- Expect inst_ready=0 and dataBus stable for all 10 cycles.
- Byte stream resumes at slot 0 after the ack.
REQ-025 Wrap: with ADDR_WIDTH=2, write 5 lines -> ram_address sequence 0,1,2,3,0.
REQ-026 Mid-operation reset: assert Reset asynchronously mid-WRITE (between clk edges).
- Expect ram_write=0 immediately and no write for the discarded line.
- The next full line is written to address 0.
